// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - two-port request arbiter and chip-select handshake adapter for the PSRAM controller
//
// Purpose:
//   Arbitrates byte read/write requests from port A (video/DMA, high priority)
//   and port B (CPU), drives one controller transaction at a time through the
//   controller's active-low, edge-triggered chip-select handshake, and returns
//   read data plus a one-cycle completion pulse to the owning port.
//
// Ports:
//   i_clkRAM, reset                 clock and synchronous active-high reset
//   i_reqX/i_weX/i_addrX/i_bankX/
//   i_wdataX                        request fields from port X (A or B), held until o_doneX
//   o_doneA, o_doneB                one-cycle completion pulses
//   o_rdata                         read data, valid with the done pulse
//   o_timeout                       sticky: controller never acknowledged a chip-select pulse
//   o_cs/o_write/o_address/
//   o_bank/o_dataToWrite            controller request interface (o_cs active low)
//   i_busy, i_dataRead              controller status and read data
module mem_req_arbiter #(
  parameter int ACK_TIMEOUT  = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        i_clkRAM,
  input  logic        reset,
  input  logic        i_reqA,
  input  logic        i_weA,
  input  logic [23:0] i_addrA,
  input  logic        i_bankA,
  input  logic [7:0]  i_wdataA,
  output logic        o_doneA,
  input  logic        i_reqB,
  input  logic        i_weB,
  input  logic [23:0] i_addrB,
  input  logic        i_bankB,
  input  logic [7:0]  i_wdataB,
  output logic        o_doneB,
  output logic [7:0]  o_rdata,
  output logic        o_timeout,
  output logic        o_cs,
  output logic        o_write,
  output logic [23:0] o_address,
  output logic        o_bank,
  output logic [7:0]  o_dataToWrite,
  input  logic        i_busy,
  input  logic [7:0]  i_dataRead
);

  localparam int AW = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT + 1)  : 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ack_cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_b;

  logic grant;
  logic grant_b;
  logic ack_expired;
  logic finish;

  always_comb begin
    // B wins when it is the only requester, or when A has had its run.
    grant_b     = i_reqB & (~i_reqA | (starve_cnt == SW'(STARVE_LIMIT)));
    // A done pulse may still be on the wire in IDLE (timeout path); holding
    // off the grant for that cycle stops the finished request from being
    // re-issued before the requester has had a chance to drop it.
    grant       = (state == S_IDLE) & (i_reqA | i_reqB) & ~i_busy
                  & ~o_doneA & ~o_doneB;
    // Expiry wins over a same-cycle busy change.
    ack_expired = (state == S_WAIT_ACK) & (ack_cnt == AW'(ACK_TIMEOUT - 1));
    // Completion is busy falling after it was seen high; the controller's
    // own data-ready flag is sticky and deliberately ignored.
    finish      = (state == S_WAIT_DONE) & ~i_busy;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_expired) state_nxt = S_IDLE;
        else if (i_busy) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (finish) state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      state         <= S_IDLE;
      ack_cnt       <= '0;
      starve_cnt    <= '0;
      owner_b       <= 1'b0;
      o_cs          <= 1'b1;
      o_write       <= 1'b0;
      o_address     <= '0;
      o_bank        <= 1'b0;
      o_dataToWrite <= '0;
      o_rdata       <= '0;
      o_doneA       <= 1'b0;
      o_doneB       <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Registered so the chip-select edge is glitch-free.
      o_cs  <= (state_nxt != S_ISSUE);

      if (state == S_WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
      else                     ack_cnt <= '0;

      if (!i_reqB)    starve_cnt <= '0;
      else if (grant) starve_cnt <= grant_b ? '0 : starve_cnt + 1'b1;

      if (grant) begin
        owner_b       <= grant_b;
        o_write       <= grant_b ? i_weB    : i_weA;
        o_address     <= grant_b ? i_addrB  : i_addrA;
        o_bank        <= grant_b ? i_bankB  : i_bankA;
        o_dataToWrite <= grant_b ? i_wdataB : i_wdataA;
      end

      o_doneA <= (finish | ack_expired) & ~owner_b;
      o_doneB <= (finish | ack_expired) &  owner_b;

      if (ack_expired)          o_timeout <= 1'b1;
      if (finish && !o_write)   o_rdata   <= i_dataRead;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA, weA, bankA, doneA;
  logic [23:0] addrA;
  logic [7:0]  wdataA;
  logic        reqB, weB, bankB, doneB;
  logic [23:0] addrB;
  logic [7:0]  wdataB;
  logic [7:0]  rdata, dataToWrite, dataRead;
  logic        timeout, cs, write, bank;
  logic [23:0] address;
  logic        model_busy, hold_busy;
  logic        busy;

  int          n_pass = 0;
  int          n_total = 0;
  int          ctrl_mode;
  int          ctrl_busy;
  logic [7:0]  ctrl_data;
  int          doneA_cnt = 0;
  int          doneB_cnt = 0;

  assign busy = model_busy | hold_busy;

  mem_req_arbiter #(.ACK_TIMEOUT(16), .STARVE_LIMIT(2)) dut (
    .i_clkRAM(clk), .reset(reset),
    .i_reqA(reqA), .i_weA(weA), .i_addrA(addrA), .i_bankA(bankA), .i_wdataA(wdataA), .o_doneA(doneA),
    .i_reqB(reqB), .i_weB(weB), .i_addrB(addrB), .i_bankB(bankB), .i_wdataB(wdataB), .o_doneB(doneB),
    .o_rdata(rdata), .o_timeout(timeout), .o_cs(cs), .o_write(write), .o_address(address),
    .o_bank(bank), .o_dataToWrite(dataToWrite), .i_busy(busy), .i_dataRead(dataRead)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (doneA) doneA_cnt++;
    if (doneB) doneB_cnt++;
  end

  // Controller model: mode 1 raises busy the cycle after the chip-select
  // pulse, holds it ctrl_busy cycles, then drops it with ctrl_data on the
  // read bus. Mode 2 never answers.
  initial begin
    model_busy = 1'b0;
    dataRead   = 8'h00;
    forever begin
      @(negedge clk);
      if (cs == 1'b0 && ctrl_mode == 1) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (ctrl_busy) @(posedge clk);
        #1 model_busy = 1'b0;
        dataRead = ctrl_data;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cs_low(input string name);
    int n = 0;
    @(negedge clk);
    while (cs !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_cs_low"}, 32'(cs), 32'd0);
  endtask

  task automatic wait_done(input bit port_b, input string name);
    int n = 0;
    @(negedge clk);
    while ((port_b ? doneB : doneA) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(port_b ? doneB : doneA), 32'd1);
  endtask

  typedef struct {
    bit          port_b;
    bit          we;
    logic [23:0] addr;
    bit          bnk;
    logic [7:0]  wdata;
    logic [7:0]  cdata;
    int          bcyc;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t        vecs[5];
  logic [23:0] order[6];

  initial begin
    int a0, b0, gap, n, bad;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 24'h012345, 1'b1, 8'h00, 8'hA5, 30, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 24'h000400, 1'b0, 8'h3C, 8'h77, 5,  8'hA5};
    vecs[2] = '{1'b1, 1'b0, 24'hFFFFFF, 1'b0, 8'h00, 8'h5A, 1,  8'h5A};
    vecs[3] = '{1'b0, 1'b1, 24'h000000, 1'b1, 8'hFF, 8'h11, 3,  8'h5A};
    vecs[4] = '{1'b0, 1'b0, 24'h800001, 1'b0, 8'h00, 8'h00, 2,  8'h00};
    order   = '{24'h0000AA, 24'h0000AA, 24'h0000BB, 24'h0000AA, 24'h0000AA, 24'h0000BB};

    reset = 1'b1; hold_busy = 1'b0; ctrl_mode = 1; ctrl_busy = 4; ctrl_data = 8'h00;
    reqA = 0; weA = 0; addrA = '0; bankA = 0; wdataA = '0;
    reqB = 0; weB = 0; addrB = '0; bankB = 0; wdataB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_done", 32'({doneA, doneB}), 32'd0);

    // Test 1: busy held during initialisation blocks issue.
    hold_busy = 1'b1; ctrl_busy = 4; ctrl_data = 8'h11;
    reqB = 1; weB = 0; addrB = 24'h000ABC; bankB = 0;
    b0 = doneB_cnt; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs !== 1'b1) bad++;
    end
    chk("t1_blocked", 32'(bad), 32'd0);
    hold_busy = 1'b0;
    wait_cs_low("t1");
    chk("t1_addr", 32'(address), 32'h000ABC);
    @(negedge clk);
    chk("t1_cs_one_cycle", 32'(cs), 32'd1);
    wait_done(1'b1, "t1");
    chk("t1_rdata", 32'(rdata), 32'h11);
    reqB = 0;
    repeat (5) @(negedge clk);
    #1 chk("t1_doneB_once", 32'(doneB_cnt - b0), 32'd1);

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      ctrl_data = v.cdata; ctrl_busy = v.bcyc;
      a0 = doneA_cnt; b0 = doneB_cnt;
      if (v.port_b) begin
        weB = v.we; addrB = v.addr; bankB = v.bnk; wdataB = v.wdata; reqB = 1;
      end else begin
        weA = v.we; addrA = v.addr; bankA = v.bnk; wdataA = v.wdata; reqA = 1;
      end
      wait_cs_low($sformatf("v%0d", i));
      chk($sformatf("v%0d_addr", i), 32'(address), 32'(v.addr));
      chk($sformatf("v%0d_write", i), 32'(write), 32'(v.we));
      chk($sformatf("v%0d_bank", i), 32'(bank), 32'(v.bnk));
      chk($sformatf("v%0d_wdata", i), 32'(dataToWrite), 32'(v.wdata));
      wait_done(v.port_b, $sformatf("v%0d", i));
      chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(v.exp_rdata));
      chk($sformatf("v%0d_other_done", i), 32'(v.port_b ? doneA : doneB), 32'd0);
      reqA = 0; reqB = 0;
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("v%0d_doneA_cnt", i), 32'(doneA_cnt - a0), v.port_b ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_doneB_cnt", i), 32'(doneB_cnt - b0), v.port_b ? 32'd1 : 32'd0);
    end

    // Test 4: both ports held continuously -> A, A, B, A, A, B.
    ctrl_busy = 3; ctrl_data = 8'h66;
    weA = 0; addrA = 24'h0000AA; bankA = 0;
    weB = 0; addrB = 24'h0000BB; bankB = 0;
    reqA = 1; reqB = 1;
    for (int k = 0; k < 6; k++) begin
      gap = 0; n = 0;
      @(negedge clk);
      while (cs !== 1'b0 && n < 300) begin
        gap++; n++;
        @(negedge clk);
      end
      chk($sformatf("t4_cs_low%0d", k), 32'(cs), 32'd0);
      chk($sformatf("t4_order%0d", k), 32'(address), 32'(order[k]));
      if (k > 0) chk($sformatf("t4_gap%0d", k), 32'(gap >= 2), 32'd1);
    end
    wait_done(1'b1, "t4_last");
    reqA = 0; reqB = 0;
    repeat (3) @(negedge clk);

    // Test 5: controller never acknowledges.
    ctrl_mode = 2;
    weA = 0; addrA = 24'h000123; reqA = 1;
    wait_cs_low("t5");
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t5_timeout_early", 32'(timeout), 32'd0);
    chk("t5_done_early", 32'(doneA), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_timeout_set", 32'(timeout), 32'd1);
    chk("t5_doneA", 32'(doneA), 32'd1);
    chk("t5_rdata_kept", 32'(rdata), 32'h66);
    reqA = 0;
    ctrl_mode = 1; ctrl_busy = 2;
    weB = 1; addrB = 24'h000777; wdataB = 8'h5C; reqB = 1;
    wait_cs_low("t5_next");
    chk("t5_next_addr", 32'(address), 32'h000777);
    wait_done(1'b1, "t5_next");
    reqB = 0;
    chk("t5_timeout_sticky", 32'(timeout), 32'd1);
    repeat (3) @(negedge clk);

    // Test 6: reset during WAIT_DONE.
    ctrl_busy = 40; ctrl_data = 8'h99;
    weB = 0; addrB = 24'h000999; reqB = 1;
    wait_cs_low("t6");
    repeat (10) @(negedge clk);
    #1 b0 = doneB_cnt; a0 = doneA_cnt;
    reset = 1'b1; reqB = 0;
    @(negedge clk);
    chk("t6_cs", 32'(cs), 32'd1);
    chk("t6_addr", 32'(address), 32'd0);
    chk("t6_bank_write", 32'({bank, write}), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    chk("t6_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    weA = 0; addrA = 24'h000555; reqA = 1;
    bad = 0; n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      if (busy === 1'b1 && cs !== 1'b1) bad++;
      n++;
    end
    chk("t6_busy_fell", 32'(busy), 32'd0);
    chk("t6_no_issue_while_busy", 32'(bad), 32'd0);
    ctrl_data = 8'h42; ctrl_busy = 2;
    wait_cs_low("t6_new");
    chk("t6_new_addr", 32'(address), 32'h000555);
    wait_done(1'b0, "t6_new");
    chk("t6_new_rdata", 32'(rdata), 32'h42);
    reqA = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_no_doneB", 32'(doneB_cnt - b0), 32'd0);
    chk("t6_doneA_once", 32'(doneA_cnt - a0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Two-port request arbiter and handshake adapter that sits directly upstream of the PSRAM memory controller.
- Accepts byte read/write requests from a high-priority video/DMA client (port A) and the CPU client (port B).
- Converts each granted request into the controller's active-low, edge-triggered chip-select handshake, then returns read data and a completion pulse to the requester.
- Guarantees one outstanding controller transaction at a time and a chip-select high gap between transactions.

Parameters:
- ACK_TIMEOUT, 16, cycles to wait for i_busy to rise after the chip-select pulse before flagging a timeout.
- STARVE_LIMIT, 2, maximum consecutive port A grants while port B is pending; the next grant goes to B.

Ports:
- i_clkRAM  in  1  RAM clock (100 MHz); all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_reqA  in  1  port A request; held together with its fields until o_doneA.
- i_weA  in  1  port A: 1 = write, 0 = read.
- i_addrA  in  24  port A byte address.
- i_bankA  in  1  port A bank: 0 = U7, 1 = U9.
- i_wdataA  in  8  port A write data.
- o_doneA  out  1  one-cycle completion pulse to port A.
- i_reqB, i_weB, i_addrB, i_bankB, i_wdataB, o_doneB  as for port A.
- o_rdata  out  8  read data; valid in the cycle of o_doneA/o_doneB; shared by both ports.
- o_timeout  out  1  sticky error flag; cleared only by reset.
- o_cs  out  1  to controller chip-select, 0 = enable.
- o_write  out  1  to controller: 0 = read, 1 = write.
- o_address  out  24  to controller address.
- o_bank  out  1  to controller bank select.
- o_dataToWrite  out  8  to controller write data.
- i_busy  in  1  from controller; 1 = busy (high throughout controller power-up initialisation).
- i_dataRead  in  8  from controller read data.

Behaviour:
- Reset values: o_cs=1, o_write=0, o_address=0, o_bank=0, o_dataToWrite=0, o_rdata=0, o_doneA=0, o_doneB=0, o_timeout=0, state=IDLE, starve counter=0, owner=A.
- State IDLE: o_cs=1. When (i_reqA|i_reqB) & !i_busy:
  - choose the port per the arbitration rule;
  - latch that port's we/addr/bank/wdata into o_write/o_address/o_bank/o_dataToWrite; record the owner;
  - go to ISSUE.
  - i_busy=1 in IDLE (controller initialising or finishing a prior job) blocks any issue.
- State ISSUE: exactly one cycle with o_cs=0; go to WAIT_ACK. The o_* fields stay stable from ISSUE until the next IDLE grant.
- State WAIT_ACK: o_cs=1.
  - i_busy=1 → go to WAIT_DONE.
  - Otherwise count; after ACK_TIMEOUT cycles set o_timeout=1, pulse the owner's done with o_rdata unchanged, and go to IDLE.
- State WAIT_DONE: o_cs=1. On i_busy=0 → go to RESPOND; for reads, register i_dataRead into o_rdata on this same edge. Writes leave o_rdata unchanged.
- State RESPOND: the owner's done=1 for exactly one cycle; go to IDLE.
- Controller done flag: the controller's "data ready" output is never cleared and must not be used. Completion is detected only as i_busy falling after it has been seen high.
- Arbitration:
  - A wins when both ports request, unless the starve counter equals STARVE_LIMIT; in that case B wins.
  - The counter increments on an A grant while i_reqB=1, and clears on any B grant or when i_reqB=0.
  - A single requester always wins.
- Back-to-back: a request still asserted in the cycle after its done pulse is treated as a new request. The minimum chip-select gap is the WAIT_ACK+WAIT_DONE+RESPOND+IDLE span, never less than 2 cycles with o_cs=1.
- Latency: a write or read is accepted at grant edge k, o_cs is low during cycle k..k+1, and done is asserted ≥4 cycles after grant plus the controller busy time.
- Reset mid-operation: return immediately to IDLE with o_cs=1; no done is issued for the aborted request. A controller transaction already in flight runs to completion, and IDLE waits on i_busy=0 before issuing again.
- Simultaneous events:
  - a request arriving during ISSUE/WAIT_* waits in IDLE;
  - i_busy falling in the same cycle as the ACK_TIMEOUT expiry counts as a timeout;
  - a requester dropping i_req mid-transaction does not abort it, and done is still pulsed.

Test Plan:
1. Hold i_busy=1 for 20 cycles with i_reqB=1 → o_cs stays 1. After i_busy=0: o_cs=0 for exactly 1 cycle, o_address=i_addrB, and o_doneB pulses once.
2. Port A read of 0x012345, bank=1; controller model raises busy for 30 cycles and returns 0xA5 → o_bank=1, o_write=0, o_rdata=0xA5 in the o_doneA cycle, o_doneB stays 0.
3. Port B write of 0x3C to 0x000400 → o_write=1, o_dataToWrite=0x3C, o_doneB pulses once, o_rdata unchanged.
4. i_reqA and i_reqB both held high continuously → grant order A, A, B, A, A, B; o_cs returns high for ≥2 cycles between each pulse.
5. Controller model never raises i_busy after the chip-select pulse → after 16 cycles o_timeout=1 (remains 1), owner done pulses, and the next request still issues.
6. Assert reset during WAIT_DONE → outputs return to reset values next cycle and no done pulse occurs; a new request issues only after i_busy falls.
